sio_ate_rx: RTL and testbench

//  Receiver/checker for the SioATE single-pin serial test stream.

---
 rtl/sio_ate_pkg.sv | 15 +
 rtl/sio_zero_run_ctr.sv | 31 +++
 rtl/sio_ate_rx.sv | 116 +++++++++++
 tb/tb_sio_ate_rx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_ate_pkg.sv
// Shared types and constants for the SioATE serial receiver.
package sio_ate_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int   DATA_W_DEF    = 10;
  localparam int   MIN_ZEROS_DEF = 16;
  localparam logic START_BIT     = 1'b1;
  localparam logic IDLE_BIT      = 1'b0;

endpackage

// File: rtl/sio_zero_run_ctr.sv
// Saturating idle-run counter; clear wins over load-1, load-1 wins over increment.
module sio_zero_run_ctr #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  input  logic load1,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/sio_ate_rx.sv
// SioATE single-pin stream receiver: hunts for an idle run, decodes LSB-first words, flags bad stop bits.
// Optional word compare against ExpWord with a saturating mismatch counter when SIO_RX_COMPARE_EN is defined.
module sio_ate_rx
  import sio_ate_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MIN_ZEROS = MIN_ZEROS_DEF
) (
  input  logic              SioClk,
  input  logic              SioRst_n,
  input  logic              SioDat,
`ifdef SIO_RX_COMPARE_EN
  input  logic [DATA_W-1:0] ExpWord,
  output logic [15:0]       MismatchCnt,
`endif
  output logic [DATA_W-1:0] RxWord,
  output logic              RxValid,
  output logic              FrameErr,
  output logic              Locked
);

  localparam int BW = $clog2(DATA_W + 1);

  logic              dat_p0;
  state_t            state;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shift;
  logic              zr_inc, zr_clr, zr_load1, zr_sat;

  // stage 0: input register
  always_ff @(posedge SioClk or negedge SioRst_n) begin
    if (!SioRst_n) dat_p0 <= 1'b0;
    else           dat_p0 <= SioDat;
  end

  // A stop bit doubles as the first zero of the next idle run.
  always_comb begin
    zr_inc   = 1'b0;
    zr_clr   = 1'b0;
    zr_load1 = 1'b0;
    case (state)
      HUNT: begin
        if (dat_p0 == IDLE_BIT) zr_inc = 1'b1;
        else                    zr_clr = 1'b1;
      end
      DATA: ;
      STOP: begin
        if (dat_p0 == IDLE_BIT) zr_load1 = 1'b1;
        else                    zr_clr   = 1'b1;
      end
      default: zr_clr = 1'b1;
    endcase
  end

  sio_zero_run_ctr #(.MAX(MIN_ZEROS)) u_zrun (
    .clk   (SioClk),
    .rst_n (SioRst_n),
    .inc   (zr_inc),
    .clr   (zr_clr),
    .load1 (zr_load1),
    .sat   (zr_sat)
  );

  // stage 1: frame FSM with registered outputs
  always_ff @(posedge SioClk or negedge SioRst_n) begin
    if (!SioRst_n) begin
      state    <= HUNT;
      bitcnt   <= '0;
      shift    <= '0;
      RxWord   <= '0;
      RxValid  <= 1'b0;
      FrameErr <= 1'b0;
      Locked   <= 1'b0;
    end else begin
      RxValid  <= 1'b0;
      FrameErr <= 1'b0;
      case (state)
        HUNT: begin
          if (dat_p0 == START_BIT && zr_sat) begin
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          shift  <= {dat_p0, shift[DATA_W-1:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == BW'(DATA_W - 1)) state <= STOP;
        end
        STOP: begin
          if (dat_p0 == IDLE_BIT) begin
            RxWord  <= shift;
            RxValid <= 1'b1;
            Locked  <= 1'b1;
          end else begin
            FrameErr <= 1'b1;
            Locked   <= 1'b0;
          end
          state <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef SIO_RX_COMPARE_EN
  always_ff @(posedge SioClk or negedge SioRst_n) begin
    if (!SioRst_n) begin
      MismatchCnt <= '0;
    end else if (state == STOP && (dat_p0 != IDLE_BIT || shift != ExpWord)
                 && MismatchCnt != 16'hFFFF) begin
      MismatchCnt <= MismatchCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sio_ate_rx.sv
// Randomized and directed bench for sio_ate_rx against a frame-level stream model.
`timescale 1ns/1ps
module tb_sio_ate_rx;

  localparam int DW = 10;
  localparam int MZ = 16;

  logic          SioClk = 1'b0;
  logic          SioRst_n = 1'b1;
  logic          SioDat = 1'b0;
  logic [DW-1:0] RxWord;
  logic          RxValid, FrameErr, Locked;
`ifdef SIO_RX_COMPARE_EN
  logic [DW-1:0] ExpWord = '0;
  logic [15:0]   MismatchCnt;
  logic [15:0]   obs_mc[$];
  logic [15:0]   exp_mc[$];
`endif

  int errors = 0;
  int checks = 0;

  bit            stim[$];
  logic          obs_v[$], obs_e[$], obs_l[$];
  logic [DW-1:0] obs_w[$];
  logic          exp_v[$], exp_e[$], exp_l[$];
  logic [DW-1:0] exp_w[$];

  sio_ate_rx #(.DATA_W(DW), .MIN_ZEROS(MZ)) dut (
    .SioClk      (SioClk),
    .SioRst_n    (SioRst_n),
    .SioDat      (SioDat),
`ifdef SIO_RX_COMPARE_EN
    .ExpWord     (ExpWord),
    .MismatchCnt (MismatchCnt),
`endif
    .RxWord      (RxWord),
    .RxValid     (RxValid),
    .FrameErr    (FrameErr),
    .Locked      (Locked)
  );

  always #5 SioClk = ~SioClk;

  task automatic add_zeros(input int n);
    repeat (n) stim.push_back(1'b0);
  endtask

  task automatic add_frame(input logic [DW-1:0] w, input bit stop);
    stim.push_back(1'b1);
    for (int k = 0; k < DW; k++) stim.push_back(w[k]);
    stim.push_back(stop);
  endtask

  // Ends on a falling edge with reset released.
  task automatic apply_reset;
    #2 SioRst_n = 1'b0;
    SioDat = 1'b0;
    @(negedge SioClk);
    SioRst_n = 1'b1;
  endtask

  // Entry at a falling edge. Sample index m sees the response to stim[m-2].
  task automatic drive_stream;
    obs_v.delete(); obs_e.delete(); obs_l.delete(); obs_w.delete();
`ifdef SIO_RX_COMPARE_EN
    obs_mc.delete();
`endif
    for (int m = 0; m < stim.size() + 2; m++) begin
      if (m != 0) @(negedge SioClk);
      obs_v.push_back(RxValid);
      obs_e.push_back(FrameErr);
      obs_l.push_back(Locked);
      obs_w.push_back(RxWord);
`ifdef SIO_RX_COMPARE_EN
      obs_mc.push_back(MismatchCnt);
`endif
      SioDat = (m < stim.size()) ? stim[m] : 1'b0;
    end
  endtask

  // Frame-level reference: scan the bit list for idle runs and frames, then
  // lay the resulting events out on the sample timeline (stop bit index + 2).
  // zr0 is the idle run already counted before stim[0]; the input register
  // holds 0 out of reset, which the receiver sees as one idle bit.
  task automatic model(input int zr0);
    int            L = stim.size();
    int            zr = zr0;
    int            i = 0;
    int            ev_kind[int];
    logic [DW-1:0] ev_word[int];
    logic [DW-1:0] w;
    logic          cur_l = 1'b0;
    logic [DW-1:0] cur_w = '0;
    logic [15:0]   cur_mc = '0;
    exp_v.delete(); exp_e.delete(); exp_l.delete(); exp_w.delete();
`ifdef SIO_RX_COMPARE_EN
    exp_mc.delete();
`endif
    while (i < L) begin
      if (stim[i] == 1'b0) begin
        zr = (zr < MZ) ? zr + 1 : MZ;
        i++;
      end else if (zr == MZ) begin
        if (i + DW + 1 >= L) break;
        for (int k = 0; k < DW; k++) w[k] = stim[i + 1 + k];
        if (stim[i + DW + 1] == 1'b0) begin
          ev_kind[i + DW + 3] = 1;
          ev_word[i + DW + 3] = w;
          zr = 1;
        end else begin
          ev_kind[i + DW + 3] = 2;
          zr = 0;
        end
        i += DW + 2;
      end else begin
        zr = 0;
        i++;
      end
    end
    for (int m = 0; m < L + 2; m++) begin
      logic v = 1'b0;
      logic e = 1'b0;
      if (ev_kind.exists(m)) begin
        if (ev_kind[m] == 1) begin
          v = 1'b1;
          cur_l = 1'b1;
          cur_w = ev_word[m];
`ifdef SIO_RX_COMPARE_EN
          if (ev_word[m] != ExpWord && cur_mc != 16'hFFFF) cur_mc++;
`endif
        end else begin
          e = 1'b1;
          cur_l = 1'b0;
          if (cur_mc != 16'hFFFF) cur_mc++;
        end
      end
      exp_v.push_back(v);
      exp_e.push_back(e);
      exp_l.push_back(cur_l);
      exp_w.push_back(cur_w);
`ifdef SIO_RX_COMPARE_EN
      exp_mc.push_back(cur_mc);
`endif
    end
  endtask

  task automatic test_reset;
    #2 SioRst_n = 1'b0;
    #1;
    checks++;
    if ({RxValid, FrameErr, Locked, RxWord} !== '0) begin
      errors++;
      $display("FAIL reset_active got v%b e%b l%b w%h want all 0", RxValid, FrameErr, Locked, RxWord);
    end
    @(negedge SioClk);
    SioRst_n = 1'b1;
    @(negedge SioClk);
    checks++;
    if ({RxValid, FrameErr, Locked, RxWord} !== '0) begin
      errors++;
      $display("FAIL reset_release got v%b e%b l%b w%h want all 0", RxValid, FrameErr, Locked, RxWord);
    end
`ifdef SIO_RX_COMPARE_EN
    checks++;
    if (MismatchCnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mismatchcnt got %h want 0000", MismatchCnt);
    end
`endif
  endtask

  task automatic test_single_frame;
    int nv = 0;
    stim.delete();
    add_zeros(21); add_frame(10'h2A5, 1'b0); add_zeros(3);
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL single_frame cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
      if (obs_v[m] === 1'b1) nv++;
    end
    checks++;
    if (nv != 1 || RxWord !== 10'h2A5 || Locked !== 1'b1) begin
      errors++;
      $display("FAIL single_frame_summary got valids=%0d w=%h l=%b want valids=1 w=2a5 l=1", nv, RxWord, Locked);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] got[$];
    stim.delete();
    add_zeros(22); add_frame(10'h000, 1'b0);
    add_zeros(22); add_frame(10'h3FF, 1'b0);
    add_zeros(22); add_frame(10'h155, 1'b0);
    add_zeros(15); add_frame(10'h2C3, 1'b0);
    add_zeros(14); add_frame(10'h0AA, 1'b0);
    add_zeros(3);
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
      if (obs_v[m] === 1'b1) got.push_back(obs_w[m]);
    end
    checks++;
    if (got.size() != 4 || got[0] !== 10'h000 || got[1] !== 10'h3FF || got[2] !== 10'h155 || got[3] !== 10'h2C3) begin
      errors++;
      $display("FAIL back_to_back_words got count=%0d want 000 3ff 155 2c3", got.size());
    end
  endtask

  task automatic test_early_one;
    int nv = 0;
    stim.delete();
    add_zeros(10); stim.push_back(1'b1);
    add_zeros(16); add_frame(10'h001, 1'b0); add_zeros(3);
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL early_one cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
      if (obs_v[m] === 1'b1 || obs_e[m] === 1'b1) nv++;
    end
    checks++;
    if (nv != 1 || RxWord !== 10'h001) begin
      errors++;
      $display("FAIL early_one_summary got pulses=%0d w=%h want pulses=1 w=001", nv, RxWord);
    end
  endtask

  task automatic test_frame_error;
    int ne = 0;
    stim.delete();
    add_zeros(20); add_frame(10'h0F0, 1'b0);
    add_zeros(20); add_frame(10'h123, 1'b1); add_zeros(3);
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL frame_error cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
      if (obs_e[m] === 1'b1) ne++;
    end
    checks++;
    if (ne != 1 || Locked !== 1'b0 || RxWord !== 10'h0F0) begin
      errors++;
      $display("FAIL frame_error_summary got errs=%0d l=%b w=%h want errs=1 l=0 w=0f0", ne, Locked, RxWord);
    end
  endtask

  task automatic test_reset_midframe;
    int nv = 0;
    stim.delete();
    add_zeros(20); add_frame(10'h0F0, 1'b0);
    add_zeros(16); stim.push_back(1'b1);
    for (int k = 0; k < 5; k++) stim.push_back(k[0] ? 1'b1 : 1'b1 & ((10'h3C3 >> k) & 1));
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL midframe_pre cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
    end
    #2 SioRst_n = 1'b0;
    #1;
    checks++;
    if ({RxValid, FrameErr, Locked, RxWord} !== '0) begin
      errors++;
      $display("FAIL midframe_async got v%b e%b l%b w%h want all 0", RxValid, FrameErr, Locked, RxWord);
    end
    @(negedge SioClk);
    SioRst_n = 1'b1;
    stim.delete();
    add_zeros(10); add_frame(10'h2AA, 1'b0);
    add_zeros(16); add_frame(10'h1B4, 1'b0); add_zeros(3);
    drive_stream();
    model(1);
    for (int m = 0; m < obs_v.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
        errors++;
        $display("FAIL midframe_post cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                 m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
      end
      if (obs_v[m] === 1'b1) nv++;
    end
    checks++;
    if (nv != 1 || RxWord !== 10'h1B4) begin
      errors++;
      $display("FAIL midframe_summary got valids=%0d w=%h want valids=1 w=1b4", nv, RxWord);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      stim.delete();
      add_zeros($urandom_range(14, 20));
      for (int f = 0; f < 8; f++) begin
        add_frame(DW'($urandom), $urandom_range(0, 4) == 0);
        if ($urandom_range(0, 3) == 0) begin
          add_zeros($urandom_range(0, 8));
          stim.push_back(1'b1);
        end
        add_zeros($urandom_range(13, 20));
      end
      add_zeros(3);
      apply_reset();
      drive_stream();
      model(1);
      for (int m = 0; m < obs_v.size(); m++) begin
        checks++;
        if ({obs_v[m], obs_e[m], obs_l[m], obs_w[m]} !== {exp_v[m], exp_e[m], exp_l[m], exp_w[m]}) begin
          errors++;
          $display("FAIL random run=%0d cyc=%0d got v%b e%b l%b w%h want v%b e%b l%b w%h",
                   r, m, obs_v[m], obs_e[m], obs_l[m], obs_w[m], exp_v[m], exp_e[m], exp_l[m], exp_w[m]);
        end
      end
    end
  endtask

`ifdef SIO_RX_COMPARE_EN
  task automatic test_compare;
    ExpWord = 10'h155;
    stim.delete();
    add_zeros(20); add_frame(10'h155, 1'b0);
    add_zeros(20); add_frame(10'h154, 1'b0);
    add_zeros(20); add_frame(10'h155, 1'b1); add_zeros(3);
    apply_reset();
    drive_stream();
    model(1);
    for (int m = 0; m < obs_mc.size(); m++) begin
      checks++;
      if ({obs_v[m], obs_e[m], obs_mc[m]} !== {exp_v[m], exp_e[m], exp_mc[m]}) begin
        errors++;
        $display("FAIL compare cyc=%0d got v%b e%b mc=%0d want v%b e%b mc=%0d",
                 m, obs_v[m], obs_e[m], obs_mc[m], exp_v[m], exp_e[m], exp_mc[m]);
      end
    end
    checks++;
    if (MismatchCnt !== 16'd2) begin
      errors++;
      $display("FAIL compare_final got mc=%0d want 2", MismatchCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_early_one();
    test_frame_error();
    test_reset_midframe();
    test_random();
`ifdef SIO_RX_COMPARE_EN
    test_compare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
